// File: rtl/replay_pkg.sv
// Shared types, constants and helpers for the experience-replay controller
// and its LFSR address generator.
package replay_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    // Fibonacci feedback masks: bit k set means register bit k feeds the XOR.
    function automatic logic [63:0] lfsr_taps(input int width);
        logic [63:0] mask;
        case (width)
            8:       mask = 64'h0000_0000_0000_00B8;
            10:      mask = 64'h0000_0000_0000_0240;
            12:      mask = 64'h0000_0000_0000_0829;
            14:      mask = 64'h0000_0000_0000_2015;
            16:      mask = 64'h0000_0000_0000_B400;
            20:      mask = 64'h0000_0000_0009_0000;
            24:      mask = 64'h0000_0000_00E1_0000;
            32:      mask = 64'h0000_0000_8020_0003;
            default: mask = (64'd3 << (width - 2));
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/replay_memory_controller_if.sv
// Control bus between agent/trainer, the replay RAM and the replay controller.
interface replay_memory_controller_if #(
    parameter int ADDR_W = 14
);
    logic              i_store_valid;
    logic              i_sample_start;
    logic              i_ram_valid;
    logic              o_ram_valid;
    logic              o_ram_rw_select;
    logic [ADDR_W-1:0] o_ram_addr;
    logic [ADDR_W:0]   o_count;
    logic              o_full;
    logic              o_sample_busy;
    logic              o_sample_done;
    logic              o_sample_reject;

    modport master (
        output i_store_valid, i_sample_start, i_ram_valid,
        input  o_ram_valid, o_ram_rw_select, o_ram_addr, o_count, o_full,
               o_sample_busy, o_sample_done, o_sample_reject
    );

    modport slave (
        input  i_store_valid, i_sample_start, i_ram_valid,
        output o_ram_valid, o_ram_rw_select, o_ram_addr, o_count, o_full,
               o_sample_busy, o_sample_done, o_sample_reject
    );
endinterface

// File: rtl/replay_lfsr.sv
// Free-running Fibonacci LFSR (shift left, feedback into bit 0); a zero seed
// is replaced by 1 so the register never locks up.
module replay_lfsr
    import replay_pkg::*;
#(
    parameter int          WIDTH = 16,
    parameter logic [63:0] SEED  = 64'hACE1,
    parameter int          OUT_W = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [OUT_W-1:0] o_value
);
    localparam logic [63:0]      TAPS_ALL = lfsr_taps(WIDTH);
    localparam logic [WIDTH-1:0] TAPS     = TAPS_ALL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SEED_W   = (SEED[WIDTH-1:0] == '0) ? WIDTH'(1) : SEED[WIDTH-1:0];

    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] lfsr_d;
    logic [WIDTH-1:0] tap_bits;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_tap
            assign tap_bits[gi] = lfsr_q[gi] & TAPS[gi];
        end
    endgenerate

    always_comb begin
        lfsr_d = lfsr_q;
        if (en) begin
            lfsr_d = {lfsr_q[WIDTH-2:0], ^tap_bits};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED_W;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign o_value = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/replay_memory_controller.sv
// Replay RAM sequencer: circular store pointer and fill count, plus minibatch
// sampling with LFSR addresses; stores always win the single RAM port.
module replay_memory_controller
    import replay_pkg::*;
#(
    parameter int          MEMORY_WIDTH = 10000,
    parameter int          BATCH_SIZE   = 32,
    parameter int          LFSR_WIDTH   = 16,
    parameter logic [63:0] LFSR_SEED    = 64'hACE1
) (
    input logic                       clk,
    input logic                       rst,
    replay_memory_controller_if.slave bus
);
    localparam int ADDR_W = clog2(MEMORY_WIDTH);
    localparam int CNT_W  = clog2(BATCH_SIZE + 1);

    localparam logic [ADDR_W:0]   MEM_CNT   = (ADDR_W + 1)'(MEMORY_WIDTH);
    localparam logic [ADDR_W:0]   BATCH_CNT = (ADDR_W + 1)'(BATCH_SIZE);
    localparam logic [CNT_W-1:0]  BATCH_LEN = CNT_W'(BATCH_SIZE);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEMORY_WIDTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [CNT_W-1:0]  issued_q, issued_d;
    logic [CNT_W-1:0]  returned_q, returned_d;
    logic              ram_valid_q, ram_valid_d;
    logic              ram_rw_q, ram_rw_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              full_q, full_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              reject_q, reject_d;

    logic [ADDR_W-1:0] cand;
    logic              cand_ok;

    replay_lfsr #(
        .WIDTH (LFSR_WIDTH),
        .SEED  (LFSR_SEED),
        .OUT_W (ADDR_W)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .en      (1'b1),
        .o_value (cand)
    );

    // Rejection sampling against the live fill count instead of a modulo.
    assign cand_ok = ({1'b0, cand} < count_q);

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        issued_d    = issued_q;
        returned_d  = returned_q;
        ram_valid_d = 1'b0;
        ram_rw_d    = RW_WRITE;
        ram_addr_d  = '0;
        reject_d    = 1'b0;

        if (bus.i_store_valid) begin
            ram_valid_d = 1'b1;
            ram_rw_d    = RW_WRITE;
            ram_addr_d  = wr_ptr_q;
            wr_ptr_d    = (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + ADDR_W'(1);
            if (count_q != MEM_CNT) begin
                count_d = count_q + (ADDR_W + 1)'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (bus.i_sample_start) begin
                    if (count_q >= BATCH_CNT) begin
                        state_d    = ISSUE;
                        issued_d   = '0;
                        returned_d = '0;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (bus.i_ram_valid) begin
                    returned_d = returned_q + CNT_W'(1);
                end
                if (!bus.i_store_valid && cand_ok) begin
                    ram_valid_d = 1'b1;
                    ram_rw_d    = RW_READ;
                    ram_addr_d  = cand;
                    issued_d    = issued_q + CNT_W'(1);
                    if (issued_q == BATCH_LEN - CNT_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (bus.i_ram_valid) begin
                    returned_d = returned_q + CNT_W'(1);
                end
                if (returned_d >= BATCH_LEN) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Done is registered on entry to DONE so it is visible during DONE.
        done_d = (state_q == DRAIN) && (state_d == DONE);
        busy_d = (state_d != IDLE);
        full_d = (count_d == MEM_CNT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            issued_q    <= '0;
            returned_q  <= '0;
            ram_valid_q <= 1'b0;
            ram_rw_q    <= 1'b0;
            ram_addr_q  <= '0;
            full_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            reject_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            issued_q    <= issued_d;
            returned_q  <= returned_d;
            ram_valid_q <= ram_valid_d;
            ram_rw_q    <= ram_rw_d;
            ram_addr_q  <= ram_addr_d;
            full_q      <= full_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            reject_q    <= reject_d;
        end
    end

    assign bus.o_ram_valid     = ram_valid_q;
    assign bus.o_ram_rw_select = ram_rw_q;
    assign bus.o_ram_addr      = ram_addr_q;
    assign bus.o_count         = count_q;
    assign bus.o_full          = full_q;
    assign bus.o_sample_busy   = busy_q;
    assign bus.o_sample_done   = done_q;
    assign bus.o_sample_reject = reject_q;

endmodule
